// File: rtl/lab2_proc_mem_arbiter.sv
// Two-requester (imem/dmem) arbiter onto one in-order memory port, with a source-tag queue for
// response routing. Define LAB2_PROC_MEM_ARB_DMEM_PRIO_EN for fixed dmem priority instead of RR.
`timescale 1ns/1ps

package lab2_proc_mem_arbiter_pkg;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

module lab2_proc_mem_arbiter
  import lab2_proc_mem_arbiter_pkg::*;
#(
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,

  input  mem_req_4B_t                          imem_reqstream_msg,
  input  logic                                 imem_reqstream_val,
  output logic                                 imem_reqstream_rdy,

  output mem_resp_4B_t                         imem_respstream_msg,
  output logic                                 imem_respstream_val,
  input  logic                                 imem_respstream_rdy,

  input  mem_req_4B_t                          dmem_reqstream_msg,
  input  logic                                 dmem_reqstream_val,
  output logic                                 dmem_reqstream_rdy,

  output mem_resp_4B_t                         dmem_respstream_msg,
  output logic                                 dmem_respstream_val,
  input  logic                                 dmem_respstream_rdy,

  output mem_req_4B_t                          mem_reqstream_msg,
  output logic                                 mem_reqstream_val,
  input  logic                                 mem_reqstream_rdy,

  input  mem_resp_4B_t                         mem_respstream_msg,
  input  logic                                 mem_respstream_val,
  output logic                                 mem_respstream_rdy,

  output logic [$clog2(p_max_outstanding):0]   num_outstanding
);

  localparam int unsigned AddrW = $clog2(p_max_outstanding);

  logic [p_max_outstanding-1:0] tags_q;
  logic [AddrW-1:0]             wr_ptr_q;
  logic [AddrW-1:0]             rd_ptr_q;
  logic [AddrW:0]               count_q;

  logic full;
  logic empty;
  logic head_dmem;
  logic grant_dmem;
  logic imem_pick;
  logic dmem_pick;
  logic can_req;
  logic resp_live;
  logic req_fire;
  logic resp_fire;

  assign full      = (count_q == (AddrW+1)'(p_max_outstanding));
  assign empty     = (count_q == '0);
  assign head_dmem = tags_q[rd_ptr_q];

`ifdef LAB2_PROC_MEM_ARB_DMEM_PRIO_EN
  always_comb begin
    grant_dmem = dmem_reqstream_val;
    imem_pick  = !dmem_reqstream_val;
    dmem_pick  = 1'b1;
  end
`else
  logic last_grant_q;

  // *_pick says "this requester would win if valid", so its rdy never looks at its own val.
  always_comb begin
    grant_dmem = dmem_reqstream_val && (!imem_reqstream_val || !last_grant_q);
    imem_pick  = !dmem_reqstream_val || last_grant_q;
    dmem_pick  = !imem_reqstream_val || !last_grant_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (req_fire) begin
      last_grant_q <= grant_dmem;
    end
  end
`endif

  always_comb begin
    can_req            = mem_reqstream_rdy && !full && !reset;
    imem_reqstream_rdy = imem_pick && can_req;
    dmem_reqstream_rdy = dmem_pick && can_req;
    mem_reqstream_val  = (imem_reqstream_val || dmem_reqstream_val) && !full && !reset;
    mem_reqstream_msg  = grant_dmem ? dmem_reqstream_msg : imem_reqstream_msg;
    req_fire           = mem_reqstream_val && mem_reqstream_rdy;

    resp_live           = !empty && !reset;
    imem_respstream_msg = mem_respstream_msg;
    dmem_respstream_msg = mem_respstream_msg;
    imem_respstream_val = resp_live && !head_dmem && mem_respstream_val;
    dmem_respstream_val = resp_live && head_dmem && mem_respstream_val;
    mem_respstream_rdy  = resp_live && (head_dmem ? dmem_respstream_rdy : imem_respstream_rdy);
    resp_fire           = mem_respstream_val && mem_respstream_rdy;
  end

  // Enqueue is already blocked when full via mem_reqstream_val, so a same-edge dequeue cannot
  // let a new tag in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (req_fire) begin
        tags_q[wr_ptr_q] <= grant_dmem;
        wr_ptr_q         <= wr_ptr_q + AddrW'(1);
      end
      if (resp_fire) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      if (req_fire && !resp_fire) begin
        count_q <= count_q + (AddrW+1)'(1);
      end else if (!req_fire && resp_fire) begin
        count_q <= count_q - (AddrW+1)'(1);
      end
    end
  end

  assign num_outstanding = count_q;

endmodule
